// File: rtl/mem_copy_master_if.sv
// Single-port data memory bus shared with the core through an external mux.
interface mem_copy_master_if;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (output mem_we, output mem_a, output mem_wd, input mem_rd);
    modport slave  (input mem_we, input mem_a, input mem_wd, output mem_rd);
endinterface

// File: rtl/mem_copy_master.sv
// DMA-style word copier: reads len words from src_addr and writes them to dst_addr,
// one read cycle then one write cycle per word, on a combinational-read memory port.
// Optional feature macro: MEMCPY_CHECKSUM_EN (running sum of copied words on checksum).
module mem_copy_master #(
    parameter int unsigned LEN_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          checksum,
    mem_copy_master_if.master    mem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [31:0]        cur_src;
    logic [31:0]        cur_dst;
    logic [31:0]        data_q;
    logic [LEN_W-1:0]   remaining;
    logic               err_q;
    logic               misaligned;
    logic               len_zero;

    assign misaligned = (|src_addr[1:0]) | (|dst_addr[1:0]);
    assign len_zero   = (len == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; len=0 takes priority over the alignment reject
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_zero || misaligned) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_READ;
                    end
                end
            end
            S_READ:  state_n = S_WRITE;
            S_WRITE: state_n = (remaining == LEN_W'(1)) ? S_DONE : S_READ;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Transfer datapath: address pointers, word counter, read-data capture, reject flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_src   <= 32'h0;
            cur_dst   <= 32'h0;
            data_q    <= 32'h0;
            remaining <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_src   <= src_addr;
                        cur_dst   <= dst_addr;
                        remaining <= len;
                        err_q     <= !len_zero && misaligned;
                    end
                end
                S_READ: begin
                    data_q  <= mem.mem_rd;
                    cur_src <= cur_src + 32'd4;
                end
                S_WRITE: begin
                    cur_dst   <= cur_dst + 32'd4;
                    remaining <= remaining - LEN_W'(1);
                end
                S_DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef MEMCPY_CHECKSUM_EN
    // Running sum of written words; cleared on accept, held after done
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= 32'h0;
        end else if ((state == S_IDLE) && start) begin
            checksum <= 32'h0;
        end else if (state == S_WRITE) begin
            checksum <= checksum + data_q;
        end
    end
`else
    assign checksum = 32'h0;
`endif

    // Output decode; bus is inert outside READ/WRITE, and reset gates the write strobe
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem.mem_we = 1'b0;
        mem.mem_a  = 32'h0;
        mem.mem_wd = 32'h0;
        case (state)
            S_READ: begin
                busy      = 1'b1;
                mem.mem_a = cur_src;
            end
            S_WRITE: begin
                busy       = 1'b1;
                mem.mem_a  = cur_dst;
                mem.mem_wd = data_q;
                mem.mem_we = reset;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master with a word-array memory and a forward-copy model.
module tb_mem_copy_master;

    localparam int unsigned LEN_W     = 10;
    localparam int unsigned MEM_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       src;
    logic [31:0]       dst;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       checksum;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int          wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_copy_master_if bus ();

    mem_copy_master #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (rst),
        .start    (start),
        .src_addr (src),
        .dst_addr (dst),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum),
        .mem      (bus)
    );

    // Memory: combinational read, write on posedge when mem_we is high
    assign bus.mem_rd = mem[bus.mem_a[11:2]];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_a[11:2]] = bus.mem_wd;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
    endtask

    task automatic compare_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        chk(tag, 32'(diffs), 32'd0);
    endtask

    // Reference copy: forward word-by-word, returns sum of words moved
    function automatic logic [31:0] model_copy(input logic [31:0] s, input logic [31:0] d, input int l);
        logic [31:0] sum = 32'h0;
        logic [31:0] v;
        for (int k = 0; k < l; k++) begin
            v = ref_mem[int'(s >> 2) + k];
            ref_mem[int'(d >> 2) + k] = v;
            sum = sum + v;
        end
        return sum;
    endfunction

    function automatic logic [31:0] exp_checksum(input logic [31:0] sum);
`ifdef MEMCPY_CHECKSUM_EN
        return sum;
`else
        return 32'h0 & sum;
`endif
    endfunction

    // One complete transfer checked against the model
    task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d, input int l);
        bit          rej;
        int          exp_cyc;
        int          cyc = 0;
        int          w0;
        logic        err_seen = 1'b0;
        logic        busy_seen = 1'b1;
        logic [31:0] sum = 32'h0;
        rej     = (l != 0) && ((s[1:0] != 2'b00) || (d[1:0] != 2'b00));
        exp_cyc = (l == 0 || rej) ? 1 : 2 * l + 1;
        if (!rej) sum = model_copy(s, d, l);
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = LEN_W'(l);
        @(posedge clk);
        for (int c = 1; c <= exp_cyc + 8 && cyc == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                cyc = c; err_seen = err; busy_seen = busy;
            end
        end
        chk({tag, ".done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, ".err"}, 32'(err_seen), 32'(rej));
        chk({tag, ".busy_in_done"}, 32'(busy_seen), 32'd0);
        chk({tag, ".writes"}, 32'(wr_cnt - w0), rej ? 32'd0 : 32'(l));
        compare_mem({tag, ".mem"});
        if (!rej) chk({tag, ".checksum"}, checksum, exp_checksum(sum));
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] d;
        int          l;
        int          w0;
        int          dones;
        int          second;
        logic [31:0] a_val;
        logic [31:0] sum;

        rst = 1'b0; start = 1'b0; src = 32'h0; dst = 32'h0; len = '0;
        fill_random();
        repeat (3) @(negedge clk);
        chk("rst.mem_we_in_reset", 32'(bus.mem_we), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst.mem_a", bus.mem_a, 32'h0);
        chk("rst.mem_wd", bus.mem_wd, 32'h0);
        chk("rst.checksum", checksum, 32'h0);

        // Basic copy of 1,2,3,4
        for (int i = 0; i < 4; i++) begin
            mem[i] = 32'(i + 1); ref_mem[i] = 32'(i + 1);
        end
        run_xfer("basic", 32'h0, 32'h100, 4);
        chk("basic.mem_0x43", mem[32'h43], 32'd4);

        run_xfer("len0", 32'h10, 32'h200, 0);
        run_xfer("misaligned", 32'h2, 32'h300, 3);

        // Overlap, dst one word above src
        fill_random();
        a_val = mem[0];
        run_xfer("overlap", 32'h0, 32'h4, 2);
        chk("overlap.mem1", mem[1], a_val);
        chk("overlap.mem2", mem[2], a_val);

        // Randomized transfers, last one misaligned
        for (int i = 0; i < 8; i++) begin
            fill_random();
            s = 32'($urandom_range(0, 400)) << 2;
            d = 32'($urandom_range(0, 400)) << 2;
            l = int'($urandom_range(1, 30));
            if (i == 7) d = d | 32'($urandom_range(1, 3));
            run_xfer($sformatf("rand%0d", i), s, d, l);
        end

        // start held high across a transfer: second accept only from IDLE
        fill_random();
        sum = model_copy(32'h0, 32'h190, 3);
        w0 = wr_cnt; dones = 0; second = 0;
        @(negedge clk);
        start = 1'b1; src = 32'h0; dst = 32'h190; len = LEN_W'(3);
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (done === 1'b1 && c <= 8) dones++;
            if (c == 7) chk("hold.done_cycle7", 32'(done), 32'd1);
            if (c == 8) chk("hold.idle_busy", 32'(busy), 32'd0);
            if (c == 9) chk("hold.second_accept", 32'(busy), 32'd1);
        end
        start = 1'b0;
        chk("hold.single_done", 32'(dones), 32'd1);
        for (int c = 10; c <= 25 && second == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) second = c;
        end
        chk("hold.second_done_cycle", 32'(second), 32'd15);
        chk("hold.writes", 32'(wr_cnt - w0), 32'd6);
        compare_mem("hold.mem");
        chk("hold.checksum", checksum, exp_checksum(sum));

        // Reset during the third word's WRITE cycle
        fill_random();
        void'(model_copy(32'h0, 32'h200, 2));
        w0 = wr_cnt; dones = 0;
        @(negedge clk);
        start = 1'b1; src = 32'h0; dst = 32'h200; len = LEN_W'(8);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) dones++;
        end
        rst = 1'b0;
        #1;
        chk("rstmid.mem_we_gated", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        chk("rstmid.busy", 32'(busy), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("rstmid.no_done", 32'(dones), 32'd0);
        chk("rstmid.writes", 32'(wr_cnt - w0), 32'd2);
        compare_mem("rstmid.mem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
